video_timing: RTL and testbench
===============================

VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 clock  input  1  pixel clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 videoMode  input  VideoMode  requested timing from the mode-select stage; sampled only at frame boundary.
REQ-004 hsync  output  1  horizontal sync, polarity per active mode.
REQ-005 vsync  output  1  vertical sync, polarity per active mode.
REQ-006 de  output  1  data enable, high in visible region.
REQ-007 counter_x  output  12  current pixel column, 0..H_TOTAL-1.
REQ-008 counter_y  output  11  current line, 0..V_TOTAL-1.
REQ-009 frame_start  output  1  one-cycle pulse at position (0,0).
REQ-010 mode_changed  output  1  one-cycle pulse at (0,0) of the first frame using a newly applied mode.

Function
REQ-011 Block SHALL hold an internal active_mode register; all timing uses active_mode, never videoMode directly.
REQ-012 H_TOTAL = h_visible+h_front_porch+h_sync+h_back_porch; V_TOTAL likewise from v_* fields; arithmetic 12-bit horizontal, 11-bit vertical, no overflow for any package mode.
REQ-013 hcnt SHALL increment every cycle, wrap to 0 after H_TOTAL-1; vcnt SHALL increment on hcnt wrap, wrap to 0 after V_TOTAL-1.
REQ-014 Region order per line/frame: visible, front porch, sync, back porch.
REQ-015 de = (hcnt < h_visible) AND (vcnt < v_visible).
REQ-016 hsync active while h_visible+h_front_porch <= hcnt < h_visible+h_front_porch+h_sync; output = h_sync_pol when active, else inverse.
REQ-017 vsync active for whole lines v_visible+v_front_porch <= vcnt < v_visible+v_front_porch+v_sync, transitions aligned to hcnt=0; polarity as REQ-016 with v_sync_pol.
REQ-018 All outputs SHALL be registered and mutually aligned: hsync/vsync/de/frame_start in a cycle describe the counter_x/counter_y shown that cycle.
REQ-019 active_mode SHALL load videoMode only on the edge where hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1; mid-frame videoMode changes SHALL be ignored until then; only the value present at that edge applies.
REQ-020 mode_changed SHALL pulse with frame_start only when the loaded value differs from the previous active_mode.
REQ-021 Same-value reload SHALL NOT pulse mode_changed and SHALL NOT disturb counters.

Reset
REQ-022 On reset_n low: hcnt=vcnt=0, active_mode=VIDEO_MODE_1080P, counter_x=0, counter_y=0, de=0, frame_start=0, mode_changed=0, hsync/vsync at 1080p inactive level (0).
REQ-023 Reset mid-frame SHALL abandon the frame immediately; first edge after release SHALL output position (0,0) with frame_start=1, de=1.
REQ-024 Reset SHALL NOT produce mode_changed.

Structure
REQ-025 VideoMode typedef (h/v visible, front_porch, sync, back_porch, sync polarity) and VIDEO_MODE_VGA/720P/1080P constants SHALL live in the shared video-modes package, shared with the mode-select stage.
REQ-026 Single module, no sub-module; counters and comparators inline.

Verification
REQ-027 Reset, 1080p held -> hsync high for counter_x 2008..2051, de low from x=1920, line length 2200, frame length 1125 lines, vsync high lines 1084..1088.
REQ-028 Switch videoMode to VGA at line 500 -> 1080p continues to (2199,1124); next frame 800x525, hsync/vsync low-active (x 656..751, lines 490..491), mode_changed=1 with that frame_start only.
REQ-029 Toggle videoMode 720p then back to 1080p within one frame -> no mode change, mode_changed never asserts.
REQ-030 720p applied -> H_TOTAL 1650, V_TOTAL 750, frame_start exactly every 1,237,500 cycles.
REQ-031 Assert reset_n low at (1000,600) for 3 cycles -> outputs at reset values during reset; first post-release output (0,0), frame_start=1, mode 1080p.
REQ-032 Change videoMode on the exact boundary edge (2199,1124) -> new mode applies to the immediately following frame.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared video-modes package: mode timing record, the standard CEA modes and
// total-length helpers used by the timing generator and the mode-select stage.
package video_timing_pkg;

    typedef struct packed {
        logic [11:0] h_visible;
        logic [11:0] h_front_porch;
        logic [11:0] h_sync;
        logic [11:0] h_back_porch;
        logic [10:0] v_visible;
        logic [10:0] v_front_porch;
        logic [10:0] v_sync;
        logic [10:0] v_back_porch;
        logic        h_sync_pol;    // level driven while hsync is active
        logic        v_sync_pol;
    } VideoMode;

    localparam VideoMode VIDEO_MODE_VGA = '{
        h_visible: 12'd640,  h_front_porch: 12'd16,  h_sync: 12'd96, h_back_porch: 12'd48,
        v_visible: 11'd480,  v_front_porch: 11'd10,  v_sync: 11'd2,  v_back_porch: 11'd33,
        h_sync_pol: 1'b0,    v_sync_pol: 1'b0
    };

    localparam VideoMode VIDEO_MODE_720P = '{
        h_visible: 12'd1280, h_front_porch: 12'd110, h_sync: 12'd40, h_back_porch: 12'd220,
        v_visible: 11'd720,  v_front_porch: 11'd5,   v_sync: 11'd5,  v_back_porch: 11'd20,
        h_sync_pol: 1'b1,    v_sync_pol: 1'b1
    };

    localparam VideoMode VIDEO_MODE_1080P = '{
        h_visible: 12'd1920, h_front_porch: 12'd88,  h_sync: 12'd44, h_back_porch: 12'd148,
        v_visible: 11'd1080, v_front_porch: 11'd4,   v_sync: 11'd5,  v_back_porch: 11'd36,
        h_sync_pol: 1'b1,    v_sync_pol: 1'b1
    };

    function automatic logic [11:0] h_total(input VideoMode m);
        return m.h_visible + m.h_front_porch + m.h_sync + m.h_back_porch;
    endfunction

    function automatic logic [10:0] v_total(input VideoMode m);
        return m.v_visible + m.v_front_porch + m.v_sync + m.v_back_porch;
    endfunction

endpackage

// File: rtl/video_timing.sv
// Raster timing generator: free-running pixel/line counters, sync/DE decode
// and frame-boundary mode switching, with every output registered and aligned.
module video_timing
    import video_timing_pkg::*;
#(
    parameter VideoMode RESET_MODE = VIDEO_MODE_1080P
) (
    input  logic        clock,
    input  logic        reset_n,
    input  VideoMode    videoMode,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] counter_x,
    output logic [10:0] counter_y,
    output logic        frame_start,
    output logic        mode_changed
);

    logic [11:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    VideoMode    active_mode_q, active_mode_d;
    logic        mode_pend_q, mode_pend_d;

    logic [11:0] counter_x_q, counter_x_d;
    logic [10:0] counter_y_q, counter_y_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        frame_start_q, frame_start_d;
    logic        mode_changed_q, mode_changed_d;

    logic [11:0] hs_start, hs_end;
    logic [10:0] vs_start, vs_end;
    logic        h_last, v_last;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        hcnt_d        = hcnt_q + 12'd1;
        vcnt_d        = vcnt_q;
        active_mode_d = active_mode_q;
        mode_pend_d   = 1'b0;

        h_last = (hcnt_q == h_total(active_mode_q) - 12'd1);
        v_last = (vcnt_q == v_total(active_mode_q) - 11'd1);

        if (h_last) begin
            hcnt_d = '0;
            vcnt_d = v_last ? '0 : vcnt_q + 11'd1;
        end

        // Mode is only ever swapped on the last pixel of a frame; the pending flag
        // is therefore high exactly while the counters sit at (0,0).
        if (h_last && v_last) begin
            active_mode_d = videoMode;
            mode_pend_d   = (videoMode != active_mode_q);
        end

        hs_start = active_mode_q.h_visible + active_mode_q.h_front_porch;
        hs_end   = hs_start + active_mode_q.h_sync;
        vs_start = active_mode_q.v_visible + active_mode_q.v_front_porch;
        vs_end   = vs_start + active_mode_q.v_sync;

        // Output stage decodes the current counters, so the counters run one
        // cycle ahead of the position shown on counter_x/counter_y.
        counter_x_d    = hcnt_q;
        counter_y_d    = vcnt_q;
        hsync_d        = ((hcnt_q >= hs_start) && (hcnt_q < hs_end)) ?
                         active_mode_q.h_sync_pol : ~active_mode_q.h_sync_pol;
        vsync_d        = ((vcnt_q >= vs_start) && (vcnt_q < vs_end)) ?
                         active_mode_q.v_sync_pol : ~active_mode_q.v_sync_pol;
        de_d           = (hcnt_q < active_mode_q.h_visible) && (vcnt_q < active_mode_q.v_visible);
        frame_start_d  = (hcnt_q == 12'd0) && (vcnt_q == 11'd0);
        mode_changed_d = mode_pend_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q         <= '0;
            vcnt_q         <= '0;
            active_mode_q  <= RESET_MODE;
            mode_pend_q    <= 1'b0;
            counter_x_q    <= '0;
            counter_y_q    <= '0;
            hsync_q        <= ~RESET_MODE.h_sync_pol;
            vsync_q        <= ~RESET_MODE.v_sync_pol;
            de_q           <= 1'b0;
            frame_start_q  <= 1'b0;
            mode_changed_q <= 1'b0;
        end else begin
            hcnt_q         <= hcnt_d;
            vcnt_q         <= vcnt_d;
            active_mode_q  <= active_mode_d;
            mode_pend_q    <= mode_pend_d;
            counter_x_q    <= counter_x_d;
            counter_y_q    <= counter_y_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            de_q           <= de_d;
            frame_start_q  <= frame_start_d;
            mode_changed_q <= mode_changed_d;
        end
    end

    assign counter_x    = counter_x_q;
    assign counter_y    = counter_y_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign de           = de_q;
    assign frame_start  = frame_start_q;
    assign mode_changed = mode_changed_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a 1080p instance checks line timing and mid-frame
// reset; a second instance with a tiny power-on mode checks frame-level behaviour.
module tb_video_timing;
    import video_timing_pkg::*;

    localparam VideoMode TINY_A = '{
        h_visible: 12'd8, h_front_porch: 12'd2, h_sync: 12'd3, h_back_porch: 12'd2,
        v_visible: 11'd4, v_front_porch: 11'd1, v_sync: 11'd2, v_back_porch: 11'd1,
        h_sync_pol: 1'b1, v_sync_pol: 1'b1
    };
    localparam VideoMode TINY_B = '{
        h_visible: 12'd6, h_front_porch: 12'd1, h_sync: 12'd2, h_back_porch: 12'd3,
        v_visible: 11'd3, v_front_porch: 11'd2, v_sync: 11'd1, v_back_porch: 11'd2,
        h_sync_pol: 1'b0, v_sync_pol: 1'b0
    };

    typedef struct packed {
        logic [11:0] x;
        logic [10:0] y;
        logic hs, vs, de, fs, mc;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n_b, rst_n_s;
    VideoMode mode_b, mode_s;

    logic [11:0] cx_b, cx_s;
    logic [10:0] cy_b, cy_s;
    logic hs_b, vs_b, de_b, fs_b, mc_b;
    logic hs_s, vs_s, de_s, fs_s, mc_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_b, t_s;
    int mc_cnt_b = 0;
    exp_t q_b[$];
    exp_t q_s[$];

    video_timing u_big (
        .clock(clk), .reset_n(rst_n_b), .videoMode(mode_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .counter_x(cx_b), .counter_y(cy_b),
        .frame_start(fs_b), .mode_changed(mc_b)
    );

    video_timing #(.RESET_MODE(TINY_A)) u_small (
        .clock(clk), .reset_n(rst_n_s), .videoMode(mode_s),
        .hsync(hs_s), .vsync(vs_s), .de(de_s),
        .counter_x(cx_s), .counter_y(cy_s),
        .frame_start(fs_s), .mode_changed(mc_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(int x, int y, bit hs, bit vs, bit d, bit fs, bit mc);
        obs_t o;
        o.x = x[11:0]; o.y = y[10:0];
        o.hs = hs; o.vs = vs; o.de = d; o.fs = fs; o.mc = mc;
        return o;
    endfunction

    function automatic obs_t cur_b();
        return '{cx_b, cy_b, hs_b, vs_b, de_b, fs_b, mc_b};
    endfunction

    function automatic obs_t cur_s();
        return '{cx_s, cy_s, hs_s, vs_s, de_s, fs_s, mc_s};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got x=%0d y=%0d hs=%b vs=%b de=%b fs=%b mc=%b want x=%0d y=%0d hs=%b vs=%b de=%b fs=%b mc=%b",
                     name, got.x, got.y, got.hs, got.vs, got.de, got.fs, got.mc,
                     want.x, want.y, want.hs, want.vs, want.de, want.fs, want.mc);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push_b(int k, int x, int y, bit hs, bit vs, bit d, bit fs, bit mc);
        exp_t e;
        e.cyc = t_b + k;
        e.v   = mk(x, y, hs, vs, d, fs, mc);
        q_b.push_back(e);
    endtask

    task automatic push_s(int k, int x, int y, bit hs, bit vs, bit d, bit fs, bit mc);
        exp_t e;
        e.cyc = t_s + k;
        e.v   = mk(x, y, hs, vs, d, fs, mc);
        q_s.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitors: pop every expectation due this cycle and compare against the DUT.
    always @(negedge clk) begin
        exp_t e;
        if (mc_b === 1'b1) mc_cnt_b++;
        while (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
            e = q_b.pop_front();
            if (e.cyc < cyc) check_int("big missed expectation cycle", cyc, e.cyc);
            else check($sformatf("big cyc %0d", e.cyc - t_b), cur_b(), e.v);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        while (q_s.size() > 0 && q_s[0].cyc <= cyc) begin
            e = q_s.pop_front();
            if (e.cyc < cyc) check_int("small missed expectation cycle", cyc, e.cyc);
            else check($sformatf("small cyc %0d", e.cyc - t_s), cur_s(), e.v);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_b = 1'b0;
        rst_n_s = 1'b0;
        mode_b  = VIDEO_MODE_1080P;
        mode_s  = TINY_A;
        repeat (3) @(negedge clk);
        check("big reset values", cur_b(), mk(0, 0, 0, 0, 0, 0, 0));
        check("small reset values", cur_s(), mk(0, 0, 0, 0, 0, 0, 0));

        // 1080p first line: de edge, hsync window, line length.
        t_b = cyc + 1;
        push_b(0,    0,    0, 0, 0, 1, 1, 0);
        push_b(1,    1,    0, 0, 0, 1, 0, 0);
        push_b(1919, 1919, 0, 0, 0, 1, 0, 0);
        push_b(1920, 1920, 0, 0, 0, 0, 0, 0);
        push_b(2007, 2007, 0, 0, 0, 0, 0, 0);
        push_b(2008, 2008, 0, 1, 0, 0, 0, 0);
        push_b(2051, 2051, 0, 1, 0, 0, 0, 0);
        push_b(2052, 2052, 0, 0, 0, 0, 0, 0);
        push_b(2199, 2199, 0, 0, 0, 0, 0, 0);
        push_b(2200, 0,    1, 0, 0, 1, 0, 0);
        rst_n_b = 1'b1;
        wait_cyc(t_b + 100);
        mode_b = VIDEO_MODE_720P;
        wait_cyc(t_b + 2500);
        mode_b = VIDEO_MODE_1080P;

        // Mid-frame reset held for three cycles.
        wait_cyc(t_b + 3000);
        rst_n_b = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("big reset hold", cur_b(), mk(0, 0, 0, 0, 0, 0, 0));
        end
        t_b = cyc + 1;
        push_b(0,    0, 0, 0, 0, 1, 1, 0);
        push_b(1,    1, 0, 0, 0, 1, 0, 0);
        push_b(2200, 0, 1, 0, 0, 1, 0, 0);
        rst_n_b = 1'b1;
        wait_cyc(t_b + 2201);
        check_int("big expectations drained", q_b.size(), 0);
        check_int("big mode_changed pulses", mc_cnt_b, 0);

        // Small instance, frame 1 (TINY_A) and frame 2 with a mid-frame request.
        t_s = cyc + 1;
        push_s(0,   0,  0, 0, 0, 1, 1, 0);
        push_s(7,   7,  0, 0, 0, 1, 0, 0);
        push_s(8,   8,  0, 0, 0, 0, 0, 0);
        push_s(10,  10, 0, 1, 0, 0, 0, 0);
        push_s(12,  12, 0, 1, 0, 0, 0, 0);
        push_s(13,  13, 0, 0, 0, 0, 0, 0);
        push_s(15,  0,  1, 0, 0, 1, 0, 0);
        push_s(60,  0,  4, 0, 0, 0, 0, 0);
        push_s(75,  0,  5, 0, 1, 0, 0, 0);
        push_s(89,  14, 5, 0, 1, 0, 0, 0);
        push_s(90,  0,  6, 0, 1, 0, 0, 0);
        push_s(105, 0,  7, 0, 0, 0, 0, 0);
        push_s(119, 14, 7, 0, 0, 0, 0, 0);
        push_s(120, 0,  0, 0, 0, 1, 1, 0);
        push_s(130, 10, 0, 1, 0, 0, 0, 0);
        push_s(239, 14, 7, 0, 0, 0, 0, 0);
        // Frame 3: TINY_B, active-low syncs.
        push_s(240, 0,  0, 1, 1, 1, 1, 1);
        push_s(241, 1,  0, 1, 1, 1, 0, 0);
        push_s(246, 6,  0, 1, 1, 0, 0, 0);
        push_s(247, 7,  0, 0, 1, 0, 0, 0);
        push_s(248, 8,  0, 0, 1, 0, 0, 0);
        push_s(249, 9,  0, 1, 1, 0, 0, 0);
        push_s(251, 11, 0, 1, 1, 0, 0, 0);
        push_s(252, 0,  1, 1, 1, 1, 0, 0);
        push_s(276, 0,  3, 1, 1, 0, 0, 0);
        push_s(300, 0,  5, 1, 0, 0, 0, 0);
        push_s(311, 11, 5, 1, 0, 0, 0, 0);
        push_s(312, 0,  6, 1, 1, 0, 0, 0);
        push_s(335, 11, 7, 1, 1, 0, 0, 0);
        // Frames 4/5: same mode after a toggle-and-restore, no pulse.
        push_s(336, 0,  0, 1, 1, 1, 1, 0);
        push_s(432, 0,  0, 1, 1, 1, 1, 0);
        push_s(438, 6,  0, 1, 1, 0, 0, 0);
        push_s(527, 11, 7, 1, 1, 0, 0, 0);
        // Frame 6: TINY_A captured only on the boundary edge.
        push_s(528, 0,  0, 0, 0, 1, 1, 1);
        push_s(536, 8,  0, 0, 0, 0, 0, 0);
        push_s(538, 10, 0, 1, 0, 0, 0, 0);
        push_s(542, 14, 0, 0, 0, 0, 0, 0);
        push_s(543, 0,  1, 0, 0, 1, 0, 0);
        push_s(647, 14, 7, 0, 0, 0, 0, 0);
        // Frame 7: back to TINY_B.
        push_s(648, 0,  0, 1, 1, 1, 1, 1);
        push_s(659, 11, 0, 1, 1, 0, 0, 0);
        push_s(660, 0,  1, 1, 1, 1, 0, 0);
        rst_n_s = 1'b1;
        wait_cyc(t_s + 130); mode_s = TINY_B;
        wait_cyc(t_s + 346); mode_s = TINY_A;
        wait_cyc(t_s + 386); mode_s = TINY_B;
        wait_cyc(t_s + 526); mode_s = TINY_A;
        wait_cyc(t_s + 527); mode_s = TINY_B;
        wait_cyc(t_s + 700);
        check_int("small expectations drained", q_s.size(), 0);

        // Reset, then request VGA: first VGA frame line 0.
        rst_n_s = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("small reset hold", cur_s(), mk(0, 0, 0, 0, 0, 0, 0));
        end
        t_s = cyc + 1;
        push_s(0,   0,   0, 0, 0, 1, 1, 0);
        push_s(8,   8,   0, 0, 0, 0, 0, 0);
        push_s(120, 0,   0, 1, 1, 1, 1, 1);
        push_s(759, 639, 0, 1, 1, 1, 0, 0);
        push_s(760, 640, 0, 1, 1, 0, 0, 0);
        push_s(775, 655, 0, 1, 1, 0, 0, 0);
        push_s(776, 656, 0, 0, 1, 0, 0, 0);
        push_s(871, 751, 0, 0, 1, 0, 0, 0);
        push_s(872, 752, 0, 1, 1, 0, 0, 0);
        push_s(919, 799, 0, 1, 1, 0, 0, 0);
        push_s(920, 0,   1, 1, 1, 1, 0, 0);
        rst_n_s = 1'b1;
        mode_s  = VIDEO_MODE_VGA;
        wait_cyc(t_s + 925);
        check_int("small VGA expectations drained", q_s.size(), 0);

        // Reset out of VGA (no pulse), then request 720p.
        rst_n_s = 1'b0;
        repeat (3) @(negedge clk);
        t_s = cyc + 1;
        push_s(0,    0,    0, 0, 0, 1, 1, 0);
        push_s(120,  0,    0, 0, 0, 1, 1, 1);
        push_s(1399, 1279, 0, 0, 0, 1, 0, 0);
        push_s(1400, 1280, 0, 0, 0, 0, 0, 0);
        push_s(1509, 1389, 0, 0, 0, 0, 0, 0);
        push_s(1510, 1390, 0, 1, 0, 0, 0, 0);
        push_s(1549, 1429, 0, 1, 0, 0, 0, 0);
        push_s(1550, 1430, 0, 0, 0, 0, 0, 0);
        push_s(1769, 1649, 0, 0, 0, 0, 0, 0);
        push_s(1770, 0,    1, 0, 0, 1, 0, 0);
        rst_n_s = 1'b1;
        mode_s  = VIDEO_MODE_720P;
        wait_cyc(t_s + 1771);
        check_int("small 720p expectations drained", q_s.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
